rr_tristate_bus_arbiter: RTL and testbench
==========================================

Name: rr_tristate_bus_arbiter

Overview:
- Upstream control stage for the 4-input tristate bus mux.
- Arbitrates four requesters round-robin and drives the mux's 2-bit select plus one-hot tristate enables.
- Guarantees break-before-make: at least one all-disabled turnaround cycle between any two grants, so two bufif1 drivers never fight on the shared net.
- Enforces a maximum hold time when other requesters are waiting.

Parameters:
- MAX_HOLD, 8: max consecutive grant cycles while another request is pending; legal range 2..255.
- TURNAROUND, 1: all-disabled cycles between grants; legal range 1..15 (0 illegal).

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- req  input  4  level requests; req[i] held high while requester i wants the bus
- sel  output  2  index of granted requester; holds last grant value when idle/turnaround
- enable  output  4  one-hot tristate enables to mux drivers; all zero when no grant
- grant_valid  output  1  high iff enable is non-zero
- preempt  output  1  one-cycle pulse when a grant is ended by MAX_HOLD timeout

Behaviour:
- Interface: one clock, clk; reset is asynchronous and active-low, rst_n.
- All outputs registered.
- Reset values: sel=2'b11 (so first arbitration favours req[0]), enable=4'b0000, grant_valid=0, preempt=0, hold_cnt=0, state=IDLE.
- States: IDLE, GRANT, TURN.
- Priority:
  - Search starts at (sel+1) mod 4 and wraps.
  - Highest-priority asserted req wins.
  - Computed combinationally from the current req and registered sel.
- IDLE:
  - If req!=0: next state GRANT; winner loaded into sel; enable=1<<winner; hold_cnt=0.
  - Latency: req sampled high at edge N -> enable high after edge N (visible in cycle N+1).
- GRANT:
  - hold_cnt increments each cycle, saturating at MAX_HOLD-1.
  - If req[sel]=0 at an edge: enable cleared, go TURN, turn_cnt=0.
  - Else if hold_cnt==MAX_HOLD-1 and any other req bit set: enable cleared, preempt=1 for one cycle, go TURN.
  - Else if hold_cnt==MAX_HOLD-1 and no other req: stay in GRANT, hold_cnt reset to 0, no preempt.
  - Release and timeout on the same edge: release wins, no preempt.
- TURN:
  - enable=0 for exactly TURNAROUND cycles; turn_cnt counts 0..TURNAROUND-1.
  - On the last cycle: arbitrate as in IDLE (go GRANT with new winner, else IDLE).
  - A requester preempted by timeout that still requests is last in priority, not excluded.
- Invariants:
  - popcount(enable)<=1 at all times.
  - enable never changes directly from one non-zero value to a different non-zero value.
- Reset mid-grant: enable drops immediately (asynchronous), state IDLE.
- req glitching during TURN is ignored except at the arbitration edge.

Optional Feature:
- Macro: RR_ARB_LOCK_EN.
- When defined:
  - Adds input port lock (1 bit), sampled only in GRANT.
  - While lock=1, the MAX_HOLD timeout is suppressed and hold_cnt saturates; release via req still ends the grant.
  - Timeout may fire on the first edge with lock=0 where the condition holds.
- When undefined: no lock port; behaviour exactly as above.

Decomposition:
- Package rr_arb_pkg:
  - state enum {IDLE, GRANT, TURN}.
  - NUM_REQ=4 and SEL_W=2 constants.
  - Width constants for hold/turn counters, derived from parameter bounds (8 and 4 bits).
- One sub-module, rr_priority_pick:
  - Purely combinational.
  - Inputs: req[3:0], last[1:0]. Outputs: any, winner[1:0].
  - Reusable by later bus stages.

Test Plan:
- Reset then req=4'b0001 held: enable=0001 one cycle after req, sel=0; drop req -> enable=0000 for 1 cycle (TURNAROUND=1), grant_valid=0, then IDLE.
- req=4'b1111 constant, MAX_HOLD=8:
  - grants rotate 0,1,2,3,0 with each grant 8 cycles high.
  - preempt pulses once per rotation.
  - one zero-enable cycle between each grant.
- req=4'b0100 only, held 30 cycles: enable stays 0100 continuously, preempt never asserted.
- req[1] drops on the same edge its hold_cnt reaches 7 while req[2]=1: no preempt, TURN, then sel=2, enable=0100.
- Assert rst_n=0 mid-GRANT between clock edges: enable=0000, sel=3 immediately; after release, req=4'b1000 -> sel=3 granted next cycle.
- With RR_ARB_LOCK_EN, req=4'b0011, lock=1 for 20 cycles: requester 0 holds 20+ cycles, no preempt; lock falls -> preempt pulses, TURN, then sel=1.

Source files
------------

// File: rtl/rr_arb_pkg.sv
// rr_arb_pkg: shared state type and widths for the round-robin tristate bus arbiter.
package rr_arb_pkg;
  typedef enum logic [1:0] {IDLE, GRANT, TURN} state_e;
  localparam int NUM_REQ = 4;
  localparam int SEL_W = 2;
  localparam int HOLD_W = 8;
  localparam int TURN_W = 4;
endpackage

// File: rtl/rr_priority_pick.sv
// rr_priority_pick: combinational round-robin pick, searching from last+1 and wrapping.
module rr_priority_pick
  import rr_arb_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic [SEL_W-1:0]   last,
  output logic               any,
  output logic [SEL_W-1:0]   winner
);
  logic [SEL_W-1:0] cand;
  always_comb begin
    any = |req;
    winner = last;
    cand = last;
    // Walk from the farthest offset inward so the nearest requester wins.
    for (int k = NUM_REQ; k >= 1; k--) begin
      cand = last + SEL_W'(k);
      winner = req[cand] ? cand : winner;
    end
  end
endmodule

// File: rtl/rr_tristate_bus_arbiter.sv
// rr_tristate_bus_arbiter: round-robin grant for a 4-way tristate mux with break-before-make
// turnaround and max-hold preemption; RR_ARB_LOCK_EN adds a lock input that suppresses preemption.
module rr_tristate_bus_arbiter
  import rr_arb_pkg::*;
#(
  parameter int MAX_HOLD   = 8,
  parameter int TURNAROUND = 1
) (
  input  logic               clk,
  input  logic               rst_n,
`ifdef RR_ARB_LOCK_EN
  input  logic               lock,
`endif
  input  logic [NUM_REQ-1:0] req,
  output logic [SEL_W-1:0]   sel,
  output logic [NUM_REQ-1:0] enable,
  output logic               grant_valid,
  output logic               preempt
);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);
  localparam logic [TURN_W-1:0] TURN_LAST = TURN_W'(TURNAROUND - 1);

  state_e state_q, state_d;
  logic [SEL_W-1:0] sel_q, sel_d, winner;
  logic [NUM_REQ-1:0] enable_q, enable_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic [TURN_W-1:0] turn_q, turn_d;
  logic grant_valid_q, preempt_q, preempt_d;
  logic any, locked, others, at_limit, arb;

`ifdef RR_ARB_LOCK_EN
  assign locked = lock;
`else
  assign locked = 1'b0;
`endif

  rr_priority_pick u_pick (.req(req), .last(sel_q), .any(any), .winner(winner));

  assign others = |(req & ~(NUM_REQ'(1) << sel_q));
  assign at_limit = hold_q == HOLD_LAST;
  assign arb = state_q == IDLE || (state_q == TURN && turn_q == TURN_LAST);

  always_comb begin
    state_d = state_q;
    sel_d = sel_q;
    enable_d = '0;
    preempt_d = 1'b0;
    hold_d = hold_q;
    turn_d = turn_q;
    if (arb) begin
      state_d = any ? GRANT : IDLE;
      sel_d = any ? winner : sel_q;
      enable_d = any ? NUM_REQ'(1) << winner : '0;
      hold_d = '0;
    end else if (state_q == TURN) begin
      turn_d = turn_q + TURN_W'(1);
    end else if (!req[sel_q]) begin
      state_d = TURN;
      turn_d = '0;
    end else if (at_limit && others && !locked) begin
      state_d = TURN;
      turn_d = '0;
      preempt_d = 1'b1;
    end else begin
      // A lone holder restarts its window; a locked holder just saturates.
      enable_d = enable_q;
      hold_d = !at_limit ? hold_q + HOLD_W'(1) : (locked ? hold_q : '0);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sel_q <= '1;
      enable_q <= '0;
      grant_valid_q <= 1'b0;
      preempt_q <= 1'b0;
      hold_q <= '0;
      turn_q <= '0;
    end else begin
      state_q <= state_d;
      sel_q <= sel_d;
      enable_q <= enable_d;
      grant_valid_q <= |enable_d;
      preempt_q <= preempt_d;
      hold_q <= hold_d;
      turn_q <= turn_d;
    end
  end

  assign sel = sel_q;
  assign enable = enable_q;
  assign grant_valid = grant_valid_q;
  assign preempt = preempt_q;
endmodule

// File: tb/tb_rr_tristate_bus_arbiter.sv
// tb_rr_tristate_bus_arbiter: directed and random checks of the arbiter against a grant/gap model.
module tb_rr_tristate_bus_arbiter;
  localparam int MAX_HOLD = 8;
  localparam int TURNAROUND = 1;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic lock = 1'b0;
  logic [3:0] req = '0;
  logic [1:0] sel;
  logic [3:0] enable;
  logic grant_valid, preempt;
  int checks = 0;
  int errors = 0;

  int m_owner = 3;
  int m_run = 0;
  int m_gap = 0;
  int m_w;
  bit m_granted = 1'b0;
  bit m_pre = 1'b0;
  logic [7:0] exp_o, got;
  logic [3:0] prev_en = '0;

  rr_tristate_bus_arbiter #(.MAX_HOLD(MAX_HOLD), .TURNAROUND(TURNAROUND)) dut (
    .clk(clk),
    .rst_n(rst_n),
`ifdef RR_ARB_LOCK_EN
    .lock(lock),
`endif
    .req(req),
    .sel(sel),
    .enable(enable),
    .grant_valid(grant_valid),
    .preempt(preempt)
  );

  always #5 clk = ~clk;

  assign got = {sel, enable, grant_valid, preempt};
  assign exp_o = {m_owner[1:0], m_granted ? 4'(1 << m_owner) : 4'b0000, m_granted, m_pre};

  function automatic int pick(logic [3:0] r, int last);
    for (int k = 1; k <= 4; k++)
      if (r[(last + k) % 4]) return (last + k) % 4;
    return -1;
  endfunction

  // Model: m_run = cycles the owner has held in its current window, m_gap = dead cycles left.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_owner = 3; m_granted = 0; m_run = 0; m_gap = 0; m_pre = 0;
    end else begin
      m_pre = 0;
      if (m_granted) begin
        if (!req[m_owner]) begin
          m_granted = 0; m_gap = TURNAROUND;
        end else if (m_run == MAX_HOLD && !lock && (req & ~(4'b0001 << m_owner)) != 4'b0000) begin
          m_granted = 0; m_gap = TURNAROUND; m_pre = 1;
        end else if (m_run == MAX_HOLD) m_run = lock ? MAX_HOLD : 1;
        else m_run++;
      end else if (m_gap > 1) m_gap--;
      else begin
        m_w = pick(req, m_owner);
        if (m_w >= 0) begin m_owner = m_w; m_granted = 1; m_run = 1; end
        m_gap = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      checks++;
      if ($countones(enable) > 1 || (prev_en != 4'b0 && enable != 4'b0 && enable != prev_en)) begin
        errors++;
        $display("FAIL invariant: enable %b after %b, want one-hot or zero between grants", enable, prev_en);
      end
      prev_en = enable;
    end else prev_en = '0;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    @(negedge clk); #2 rst_n = 1'b0; req = '0; lock = 1'b0;
    @(negedge clk); #2 rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req = 4'b1111; #1;
    checks++;
    if (got !== 8'b11_0000_0_0) begin errors++; $display("FAIL reset_values: got %b want %b", got, 8'b11_0000_0_0); end
    tick();
    checks++;
    if (got !== exp_o || got !== 8'b11_0000_0_0) begin errors++; $display("FAIL reset_held: got %b want %b", got, exp_o); end
    @(negedge clk); #2 rst_n = 1'b1; req = '0;
  endtask

  task automatic test_single();
    apply_reset();
    req = 4'b0001;
    tick();
    checks++;
    if (enable !== 4'b0001 || sel !== 2'd0 || grant_valid !== 1'b1) begin errors++; $display("FAIL single_grant: got sel %0d en %b gv %b want 0 0001 1", sel, enable, grant_valid); end
    for (int c = 0; c < 3; c++) begin
      tick();
      checks++;
      if (got !== exp_o) begin errors++; $display("FAIL single_hold: got %b want %b", got, exp_o); end
    end
    req = 4'b0000;
    tick();
    checks++;
    if (enable !== 4'b0000 || grant_valid !== 1'b0 || sel !== 2'd0 || got !== exp_o) begin errors++; $display("FAIL single_turn: got %b want %b", got, exp_o); end
    tick();
    checks++;
    if (enable !== 4'b0000 || got !== exp_o) begin errors++; $display("FAIL single_idle: got %b want %b", got, exp_o); end
  endtask

  task automatic test_rotation();
    int starts[$];
    int lens[$];
    int run = 0;
    int npre = 0;
    logic [3:0] last_en = '0;
    apply_reset();
    req = 4'b1111;
    for (int c = 0; c < 44; c++) begin
      tick();
      checks++;
      if (got !== exp_o) begin errors++; $display("FAIL rotation_model c%0d: got %b want %b", c, got, exp_o); end
      if (enable != 4'b0 && last_en == 4'b0) starts.push_back(int'(sel));
      if (enable != 4'b0) run++;
      else if (run != 0) begin lens.push_back(run); run = 0; end
      npre += int'(preempt);
      last_en = enable;
    end
    checks++;
    if (starts.size() != 5) begin errors++; $display("FAIL rotation_count: got %0d grants want 5", starts.size()); end
    else for (int k = 0; k < 5; k++) begin
      checks++;
      if (starts[k] != k % 4) begin errors++; $display("FAIL rotation_order[%0d]: got %0d want %0d", k, starts[k], k % 4); end
    end
    checks++;
    if (lens.size() != 4 || lens[0] != 8 || lens[1] != 8 || lens[2] != 8 || lens[3] != 8) begin errors++; $display("FAIL rotation_len: got %0d runs (first %0d) want 4 of 8", lens.size(), lens.size() ? lens[0] : -1); end
    checks++;
    if (npre != 4) begin errors++; $display("FAIL rotation_preempt: got %0d want 4", npre); end
  endtask

  task automatic test_solo_hold();
    apply_reset();
    req = 4'b0100;
    for (int c = 0; c < 30; c++) begin
      tick();
      checks++;
      if (enable !== 4'b0100 || preempt !== 1'b0 || got !== exp_o) begin errors++; $display("FAIL solo_hold c%0d: got %b want %b", c, got, exp_o); end
    end
  endtask

  task automatic test_release_on_timeout();
    apply_reset();
    req = 4'b0110;
    for (int c = 0; c < 8; c++) begin
      tick();
      checks++;
      if (got !== exp_o) begin errors++; $display("FAIL release_model c%0d: got %b want %b", c, got, exp_o); end
    end
    checks++;
    if (sel !== 2'd1 || enable !== 4'b0010) begin errors++; $display("FAIL release_owner: got sel %0d en %b want 1 0010", sel, enable); end
    req = 4'b0100;
    tick();
    checks++;
    if (enable !== 4'b0000 || preempt !== 1'b0 || grant_valid !== 1'b0) begin errors++; $display("FAIL release_wins: got en %b pre %b want 0000 0", enable, preempt); end
    tick();
    checks++;
    if (sel !== 2'd2 || enable !== 4'b0100 || got !== exp_o) begin errors++; $display("FAIL release_next: got sel %0d en %b want 2 0100", sel, enable); end
  endtask

  task automatic test_async_reset();
    apply_reset();
    req = 4'b0001;
    tick(); tick(); tick();
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (enable !== 4'b0000 || sel !== 2'd3 || grant_valid !== 1'b0 || got !== exp_o) begin errors++; $display("FAIL async_reset: got %b want %b", got, 8'b11_0000_0_0); end
    @(negedge clk); #2 rst_n = 1'b1; req = 4'b1000;
    tick();
    checks++;
    if (sel !== 2'd3 || enable !== 4'b1000 || got !== exp_o) begin errors++; $display("FAIL async_regrant: got sel %0d en %b want 3 1000", sel, enable); end
  endtask

`ifdef RR_ARB_LOCK_EN
  task automatic test_lock();
    apply_reset();
    req = 4'b0011;
    lock = 1'b1;
    for (int c = 0; c < 22; c++) begin
      tick();
      checks++;
      if (enable !== 4'b0001 || preempt !== 1'b0 || got !== exp_o) begin errors++; $display("FAIL lock_hold c%0d: got %b want %b", c, got, exp_o); end
    end
    lock = 1'b0;
    tick();
    checks++;
    if (preempt !== 1'b1 || enable !== 4'b0000) begin errors++; $display("FAIL lock_release: got pre %b en %b want 1 0000", preempt, enable); end
    tick();
    checks++;
    if (sel !== 2'd1 || enable !== 4'b0010 || got !== exp_o) begin errors++; $display("FAIL lock_next: got sel %0d en %b want 1 0010", sel, enable); end
  endtask
`endif

  task automatic test_random();
    apply_reset();
    for (int c = 0; c < 800; c++) begin
      for (int i = 0; i < 4; i++)
        if ($urandom_range(0, 7) == 0) req[i] = ~req[i];
`ifdef RR_ARB_LOCK_EN
      if ($urandom_range(0, 9) == 0) lock = ~lock;
`endif
      tick();
      checks++;
      if (got !== exp_o) begin errors++; $display("FAIL random c%0d req %b: got %b want %b", c, req, got, exp_o); end
    end
  endtask

  initial begin
    #2;
    test_reset();
    test_single();
    test_rotation();
    test_solo_hold();
    test_release_on_timeout();
    test_async_reset();
`ifdef RR_ARB_LOCK_EN
    test_lock();
`endif
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
